// File: rtl/seq_pattern_tx.sv
// seq_pattern_tx: serial frame transmitter feeding a downstream sequence detector.
// A frame sends the low LEN bits of DATA MSB-first, then idles GAP_CYCLES cycles
// before accepting the next LOAD. HOLD freezes the shifter without losing a bit.
module seq_pattern_tx #(
  parameter int GAP_CYCLES = 1
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       LOAD,
  input  logic [7:0] DATA,
  input  logic [3:0] LEN,
  input  logic       HOLD,
  output logic       I,
  output logic       VALID,
  output logic       BUSY,
  output logic       DONE,
  output logic       Qa,
  output logic       Qb
);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    SHIFT   = 2'b01,
    GAP     = 2'b10,
    ILLEGAL = 2'b11
  } state_t;

  // Last value of the gap counter before returning to IDLE; unused when there is no gap.
  localparam logic [2:0] GAP_LAST = (GAP_CYCLES > 0) ? 3'(GAP_CYCLES - 1) : 3'd0;
  localparam logic       HAS_GAP  = (GAP_CYCLES > 0);

  state_t     state_q, state_d;
  logic [7:0] data_q, data_d;
  logic [3:0] len_q, len_d;
  logic [2:0] count_q, count_d;
  logic [2:0] gap_q, gap_d;

  logic [3:0] eff_len;
  logic [2:0] bit_idx;
  logic       last_bit;

  // Effective length clamps out-of-range requests (0 or >8) to a full byte; the
  // bit index wraps modulo 8 so a stored length of 8 addresses DATA[7] first.
  always_comb begin
    eff_len  = ((LEN == 4'd0) || (LEN > 4'd8)) ? 4'd8 : LEN;
    bit_idx  = len_q[2:0] - 3'd1 - count_q;
    last_bit = ({1'b0, count_q} == (len_q - 4'd1));
  end

  // Next-state and Mealy outputs; everything defaults to holding state and quiet outputs.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    len_d   = len_q;
    count_d = count_q;
    gap_d   = gap_q;
    I       = 1'b0;
    VALID   = 1'b0;
    DONE    = 1'b0;
    case (state_q)
      IDLE: begin
        if (LOAD) begin
          data_d  = DATA;
          len_d   = eff_len;
          count_d = 3'd0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        I = data_q[bit_idx];
        if (!HOLD) begin
          VALID = 1'b1;
          if (last_bit) begin
            DONE    = 1'b1;
            count_d = 3'd0;
            gap_d   = 3'd0;
            state_d = HAS_GAP ? GAP : IDLE;
          end else begin
            count_d = count_q + 3'd1;
          end
        end
      end
      GAP: begin
        if (gap_q == GAP_LAST) begin
          gap_d   = 3'd0;
          state_d = IDLE;
        end else begin
          gap_d = gap_q + 3'd1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset taking priority over all inputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      data_q  <= 8'd0;
      len_q   <= 4'd0;
      count_q <= 3'd0;
      gap_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      len_q   <= len_d;
      count_q <= count_d;
      gap_q   <= gap_d;
    end
  end

  // The state encoding is exported directly so the detector side can observe it.
  always_comb begin
    Qa   = state_q[1];
    Qb   = state_q[0];
    BUSY = state_q[1] | state_q[0];
  end

endmodule

// File: tb/tb_seq_pattern_tx.sv
// tb_seq_pattern_tx: table-driven frames with a bit scoreboard, plus hand-written
// sequences for reset, LOAD blocking/holding and the zero-gap configuration.
module tb_seq_pattern_tx;

  logic       CLK = 1'b0;
  logic       RST, LOAD, HOLD;
  logic [7:0] DATA;
  logic [3:0] LEN;
  logic       I, VALID, BUSY, DONE, Qa, Qb;
  logic       I0, VALID0, BUSY0, DONE0, Qa0, Qb0;

  int         checks = 0;
  int         errors = 0;
  logic       expQ[$];
  logic       monEn = 1'b0;
  logic       popBit;
  logic [7:0] rxBits = 8'd0;
  int         rxTotal = 0;

  typedef struct {
    logic [7:0] data;
    logic [3:0] len;
    int         holdAt;
    int         holdLen;
    int         expBusy;
    string      tag;
  } vec_t;

  vec_t vecs[8];

  always #5 CLK = ~CLK;

  seq_pattern_tx #(.GAP_CYCLES(1)) dut (
    .CLK(CLK), .RST(RST), .LOAD(LOAD), .DATA(DATA), .LEN(LEN), .HOLD(HOLD),
    .I(I), .VALID(VALID), .BUSY(BUSY), .DONE(DONE), .Qa(Qa), .Qb(Qb)
  );

  seq_pattern_tx #(.GAP_CYCLES(0)) dut0 (
    .CLK(CLK), .RST(RST), .LOAD(LOAD), .DATA(DATA), .LEN(LEN), .HOLD(HOLD),
    .I(I0), .VALID(VALID0), .BUSY(BUSY0), .DONE(DONE0), .Qa(Qa0), .Qb(Qb0)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Scoreboard side: every valid bit pops one expected bit; DONE must mark the last one.
  always @(negedge CLK) begin
    if (monEn) begin
      checkOutput("busy_vs_state", {31'd0, BUSY}, {31'd0, Qa | Qb});
      if (VALID) begin
        if (expQ.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_bit: got VALID=1 I=%0b expected no payload", I);
        end else begin
          popBit = expQ.pop_front();
          checkOutput("serial_bit", {31'd0, I}, {31'd0, popBit});
          checkOutput("done_on_last", {31'd0, DONE}, (expQ.size() == 0) ? 32'd1 : 32'd0);
        end
        rxBits = {rxBits[6:0], I};
        rxTotal++;
      end else begin
        checkOutput("done_quiet", {31'd0, DONE}, 32'd0);
        if (!(Qa == 1'b0 && Qb == 1'b1)) checkOutput("i_quiet", {31'd0, I}, 32'd0);
      end
    end
  end

  task automatic pushFrame(input logic [7:0] d, input int eff);
    for (int k = eff - 1; k >= 0; k--) expQ.push_back(d[k]);
  endtask

  task automatic applyStimulus(input logic [7:0] d, input logic [3:0] l, input int holdAt,
                               input int holdLen, input bit junk, input int expBusy,
                               input string tag);
    int         eff, busyN, bitIdx, holdLeft, startRx;
    logic [7:0] mask;
    eff = ((l == 4'd0) || (l > 4'd8)) ? 8 : int'(l);
    pushFrame(d, eff);
    startRx = rxTotal;
    DATA = d; LEN = l; LOAD = 1'b1; HOLD = 1'b0;
    tick();
    LOAD = 1'b0;
    checkOutput({tag, "_first_valid"}, {29'd0, Qa, Qb, VALID}, 32'b011);
    busyN = 0; bitIdx = 0; holdLeft = holdLen;
    while (BUSY && busyN < 64) begin
      if (junk) begin
        LOAD = 1'b1; DATA = ~d; LEN = 4'd3;
      end
      if (bitIdx < eff && bitIdx == holdAt && holdLeft > 0) begin
        HOLD = 1'b1;
        holdLeft--;
        #1;
        checkOutput({tag, "_hold_valid"}, {31'd0, VALID}, 32'd0);
        checkOutput({tag, "_hold_done"}, {31'd0, DONE}, 32'd0);
        checkOutput({tag, "_hold_state"}, {30'd0, Qa, Qb}, 32'b01);
        checkOutput({tag, "_hold_bit"}, {31'd0, I}, {31'd0, d[eff - 1 - bitIdx]});
      end else begin
        HOLD = 1'b0;
        if (bitIdx < eff) bitIdx++;
      end
      busyN++;
      tick();
    end
    HOLD = 1'b0;
    mask = (eff == 8) ? 8'hFF : 8'((1 << eff) - 1);
    checkOutput({tag, "_busy_cycles"}, busyN, expBusy);
    checkOutput({tag, "_bits_sent"}, rxTotal - startRx, eff);
    checkOutput({tag, "_payload"}, {24'd0, rxBits & mask}, {24'd0, d & mask});
    checkOutput({tag, "_queue_drained"}, expQ.size(), 0);
  endtask

  initial begin
    logic [5:0] gap0Exp[6];
    int         n;

    vecs[0] = '{8'hB4, 4'd8,  -1, 0, 9,  "b4_len8"};
    vecs[1] = '{8'h05, 4'd3,  -1, 0, 4,  "05_len3"};
    vecs[2] = '{8'hA5, 4'd0,  -1, 0, 9,  "len0_full"};
    vecs[3] = '{8'h3C, 4'd12, -1, 0, 9,  "len12_full"};
    vecs[4] = '{8'h80, 4'd1,  -1, 0, 2,  "len1"};
    vecs[5] = '{8'hB4, 4'd8,   3, 2, 11, "hold_bit4"};
    vecs[6] = '{8'hB4, 4'd8,   7, 1, 10, "hold_last"};
    vecs[7] = '{8'h6D, 4'd5,   0, 1, 7,  "hold_first"};

    gap0Exp[0] = 6'b011110;
    gap0Exp[1] = 6'b011101;
    gap0Exp[2] = 6'b000000;
    gap0Exp[3] = 6'b011110;
    gap0Exp[4] = 6'b011101;
    gap0Exp[5] = 6'b000000;

    RST = 1'b1; LOAD = 1'b0; HOLD = 1'b0; DATA = 8'd0; LEN = 4'd0;
    tick();
    tick();
    RST = 1'b0;
    checkOutput("reset_outputs", {26'd0, Qa, Qb, I, VALID, BUSY, DONE}, 32'd0);
    checkOutput("reset_outputs_gap0", {26'd0, Qa0, Qb0, I0, VALID0, BUSY0, DONE0}, 32'd0);
    monEn = 1'b1;

    for (int v = 0; v < 8; v++)
      applyStimulus(vecs[v].data, vecs[v].len, vecs[v].holdAt, vecs[v].holdLen, 1'b0,
                    vecs[v].expBusy, vecs[v].tag);

    // LOAD hammered through SHIFT, DONE and GAP is ignored, then taken in IDLE.
    applyStimulus(8'hB4, 4'd8, -1, 0, 1'b1, 9, "load_blocked");
    pushFrame(8'h4B, 3);
    tick();
    LOAD = 1'b0;
    checkOutput("reload_start", {30'd0, Qa, Qb}, 32'b01);
    n = 0;
    while (BUSY && n < 64) begin
      n++;
      tick();
    end
    checkOutput("reload_busy_cycles", n, 4);
    checkOutput("reload_payload", {29'd0, rxBits[2:0]}, 32'b011);

    // Reset in the middle of a frame aborts it without DONE.
    pushFrame(8'hB4, 8);
    DATA = 8'hB4; LEN = 4'd8; LOAD = 1'b1;
    tick();
    LOAD = 1'b0;
    tick();
    tick();
    RST = 1'b1;
    tick();
    checkOutput("abort_outputs", {26'd0, Qa, Qb, I, VALID, BUSY, DONE}, 32'd0);
    expQ.delete();
    LOAD = 1'b1; DATA = 8'hFF; LEN = 4'd8;
    tick();
    checkOutput("rst_priority", {30'd0, Qa, Qb}, 32'b00);
    RST = 1'b0;
    applyStimulus(8'h96, 4'd8, -1, 0, 1'b0, 9, "post_abort");

    // Zero-gap instance with LOAD held: exactly one IDLE cycle between frames.
    monEn = 1'b0;
    RST = 1'b1; LOAD = 1'b0;
    tick();
    tick();
    RST = 1'b0;
    expQ.delete();
    DATA = 8'h02; LEN = 4'd2; LOAD = 1'b1;
    tick();
    for (int c = 0; c < 6; c++) begin
      checkOutput($sformatf("gap0_cycle%0d", c), {26'd0, Qa0, Qb0, BUSY0, VALID0, I0, DONE0},
                  {26'd0, gap0Exp[c]});
      tick();
    end
    LOAD = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
